// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Operands are latched at issue; the result is committed to HI/LO when the busy period ends.
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_hi,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] out
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state, state_d;
   logic [CW-1:0]  count, count_d;
   logic [2:0]     op_q, op_d;
   logic [31:0]    a_q, a_d, b_q, b_d, hi_d, lo_d;

   logic signed [63:0] sprod;
   logic [63:0]        uprod;
   logic               a_neg, b_neg;
   logic [31:0]        ua, ub, ubd, qmag, rmag, quot, rem;

   assign sprod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign uprod = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
   assign a_neg = (op_q == OP_DIV) && a_q[31];
   assign b_neg = (op_q == OP_DIV) && b_q[31];
   assign ua    = a_neg ? -a_q : a_q;
   assign ub    = b_neg ? -b_q : b_q;
   assign ubd   = (ub == 32'd0) ? 32'd1 : ub;
   assign qmag  = ua / ubd;
   assign rmag  = ua % ubd;
   assign quot  = (a_neg ^ b_neg) ? -qmag : qmag;
   assign rem   = a_neg ? -rmag : rmag;

   always_comb begin
      state_d = state;
      count_d = count;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi;
      lo_d    = lo;
      case (state)
         IDLE: begin
            if (start) begin
               case (mdu_op)
                  OP_MULT, OP_MULTU: begin
                     op_d    = mdu_op;
                     a_d     = a;
                     b_d     = b;
                     count_d = CW'(MULT_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     op_d    = mdu_op;
                     a_d     = a;
                     b_d     = b;
                     count_d = CW'(DIV_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (count == '0) begin
               state_d = IDLE;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = sprod;
                  OP_MULTU: {hi_d, lo_d} = uprod;
                  OP_DIV, OP_DIVU: begin
                     // divide by zero leaves HI/LO untouched
                     if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                     end
                  end
                  default: ;
               endcase
            end else begin
               count_d = count - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_d;
         count <= count_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         hi    <= hi_d;
         lo    <= lo_d;
      end
   end

   assign busy = (state == RUN);
   assign out  = rd_hi ? hi : lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (default 5/10-cycle latencies).
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] a, b;
   logic        rd_hi;
   logic        busy;
   logic [31:0] hi, lo, out;

   int checks = 0;
   int errors = 0;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .a(a), .b(b),
      .rd_hi(rd_hi), .busy(busy), .hi(hi), .lo(lo), .out(out)
   );

   always #5 clk = ~clk;

   // Drive a one-cycle start strobe; returns at the negedge after the issuing edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      start = 1'b1; mdu_op = op; a = va; b = vb;
      @(negedge clk);
      start = 1'b0; mdu_op = 3'd0; a = '0; b = '0;
   endtask

   // Counts busy cycles, bounded; ends at the negedge where busy has dropped.
   task automatic wait_busy(output int n);
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; mdu_op = '0; a = '0; b = '0; rd_hi = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || out !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b hi=%h lo=%h out=%h, want 0/0/0/0", busy, hi, lo, out);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult;
      int n;
      issue(3'd1, 32'hFFFFFFFE, 32'd3);
      wait_busy(n);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL mult_busy: got %0d cycles, want 5", n); end
      checks++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
         errors++; $display("FAIL mult_result: hi=%h lo=%h, want ffffffff/fffffffa", hi, lo);
      end
      rd_hi = 1'b1; #1;
      checks++;
      if (out !== 32'hFFFFFFFF) begin errors++; $display("FAIL out_hi: got %h want ffffffff", out); end
      rd_hi = 1'b0; #1;
      checks++;
      if (out !== 32'hFFFFFFFA) begin errors++; $display("FAIL out_lo: got %h want fffffffa", out); end
   endtask

   task automatic test_multu;
      int n;
      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_busy(n);
      checks++;
      if (n !== 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         errors++;
         $display("FAIL multu: n=%0d hi=%h lo=%h, want 5/fffffffe/00000001", n, hi, lo);
      end
   endtask

   task automatic test_div;
      int n;
      issue(3'd3, 32'hFFFFFFF9, 32'd2);
      wait_busy(n);
      checks++;
      if (n !== 10) begin errors++; $display("FAIL div_busy: got %0d cycles, want 10", n); end
      checks++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL div_signed: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
      end
      issue(3'd4, 32'd7, 32'd2);
      wait_busy(n);
      checks++;
      if (n !== 10 || lo !== 32'd3 || hi !== 32'd1) begin
         errors++; $display("FAIL divu: n=%0d hi=%h lo=%h, want 10/1/3", n, hi, lo);
      end
      issue(3'd4, 32'hFFFFFFF9, 32'd2);
      wait_busy(n);
      checks++;
      if (lo !== 32'h7FFFFFFC || hi !== 32'd1) begin
         errors++; $display("FAIL divu_big: hi=%h lo=%h, want 1/7ffffffc", hi, lo);
      end
   endtask

   task automatic test_div_edge;
      int n;
      issue(3'd5, 32'h11, 32'd0);
      issue(3'd6, 32'h22, 32'd0);
      issue(3'd3, 32'd100, 32'd0);
      checks++;
      if (busy !== 1'b1 || hi !== 32'h11 || lo !== 32'h22) begin
         errors++; $display("FAIL div0_during_run: busy=%b hi=%h lo=%h, want 1/11/22", busy, hi, lo);
      end
      wait_busy(n);
      checks++;
      if (n !== 10 || hi !== 32'h11 || lo !== 32'h22) begin
         errors++; $display("FAIL div0: n=%0d hi=%h lo=%h, want 10/11/22", n, hi, lo);
      end
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_busy(n);
      checks++;
      if (lo !== 32'h80000000 || hi !== 32'd0) begin
         errors++; $display("FAIL div_ovf: hi=%h lo=%h, want 0/80000000", hi, lo);
      end
   endtask

   task automatic test_mthi;
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1; mdu_op = 3'd5; a = 32'hABCD;
      @(negedge clk);
      seen = busy;
      start = 1'b0; mdu_op = 3'd0; a = '0;
      @(negedge clk);
      seen = seen | busy;
      checks++;
      if (seen !== 1'b0 || hi !== 32'hABCD || lo !== 32'h80000000) begin
         errors++; $display("FAIL mthi: busy_seen=%b hi=%h lo=%h, want 0/abcd/80000000", seen, hi, lo);
      end
      issue(3'd0, 32'h1234, 32'd1);
      issue(3'd7, 32'h5678, 32'd1);
      checks++;
      if (busy !== 1'b0 || hi !== 32'hABCD || lo !== 32'h80000000) begin
         errors++; $display("FAIL none_op: busy=%b hi=%h lo=%h, want 0/abcd/80000000", busy, hi, lo);
      end
   endtask

   task automatic test_busy_ignore;
      int n;
      issue(3'd1, 32'd5, 32'd6);
      // now in busy cycle 1; strobe MTLO and MTHI during busy cycles 2 and 3
      start = 1'b1; mdu_op = 3'd6; a = 32'h999;
      @(negedge clk);
      mdu_op = 3'd5; a = 32'h777;
      @(negedge clk);
      start = 1'b0; mdu_op = 3'd0; a = '0;
      checks++;
      if (lo !== 32'h80000000 || hi !== 32'hABCD) begin
         errors++; $display("FAIL busy_mt: hi=%h lo=%h, want abcd/80000000", hi, lo);
      end
      wait_busy(n);
      checks++;
      if (n !== 3 || hi !== 32'd0 || lo !== 32'd30) begin
         errors++; $display("FAIL busy_ignore: n=%0d hi=%h lo=%h, want 3/0/1e", n, hi, lo);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      issue(3'd3, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_async: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      repeat (15) begin
         @(negedge clk);
         if (busy) n++;
      end
      checks++;
      if (n !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_late: busy_cycles=%0d hi=%h lo=%h, want 0/0/0", n, hi, lo);
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_multu;
      test_div;
      test_div_edge;
      test_mthi;
      test_busy_ignore;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
